alu_seq_ctrl: RTL
=================

# alu_seq_ctrl

Issue sequencer that sits between an instruction-side requester and the 32-bit MIPS ALU. It accepts one operation at a time over a valid/ready handshake and drives the ALU operand, operation, shamt, stall and flush pins. It waits out multi-cycle operations while ALU_Stall is high, then captures Result, HI, LO, BZero and EXC_Ov into a response register returned over a second valid/ready handshake. It also enforces a stall watchdog and honours an asynchronous-to-the-op flush request.

## Interface
Parameters:
- TIMEOUT_W, 8: width of stall watchdog counter.
- TIMEOUT_MAX, 8'd200: cycles of continuous ALU_Stall before abort.

Ports:
- clock  in  1  single design clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept request.
- req_a  in  32  operand A.
- req_b  in  32  operand B.
- req_op  in  5  ALU operation code.
- req_shamt  in  5  shift amount.
- flush  in  1  abort in-flight operation.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_result  out  32  captured Result.
- rsp_hi  out  32  captured HI.
- rsp_lo  out  32  captured LO.
- rsp_bzero  out  1  captured BZero.
- rsp_ov  out  1  captured EXC_Ov.
- rsp_timeout  out  1  response produced by watchdog abort.
- alu_a  out  32  to ALU A.
- alu_b  out  32  to ALU B.
- alu_op  out  5  to ALU Operation.
- alu_shamt  out  5  to ALU Shamt.
- alu_ex_stall  out  1  to ALU EX_Stall.
- alu_ex_flush  out  1  to ALU EX_Flush.
- alu_result  in  32  from ALU Result.
- alu_hi  in  32  from ALU out_HI.
- alu_lo  in  32  from ALU out_LO.
- alu_bzero  in  1  from ALU BZero.
- alu_ov  in  1  from ALU EXC_Ov.
- alu_stall  in  1  from ALU ALU_Stall.

## Operation
- FSM states: IDLE, ISSUE, EXEC, RESP, FLUSH.
- IDLE: req_ready=1. On req_valid, register A/B/op/shamt into the alu_* outputs and go to ISSUE.
- ISSUE: alu_ex_stall=0 for one cycle (the operation is presented). Go to EXEC.
- EXEC: alu_ex_stall=1 (freeze further EX advance). If alu_stall=0, capture all alu_* results into the rsp_* registers, set rsp_timeout=0 and go to RESP. If alu_stall=1, increment the watchdog. When the watchdog reaches TIMEOUT_MAX, capture rsp_timeout=1 with zeroed data and go to FLUSH.
- RESP: rsp_valid=1 and the rsp_* registers are held stable. On rsp_ready, go to IDLE.
- FLUSH: alu_ex_flush=1 for exactly one cycle, then go to RESP when rsp_timeout=1, otherwise go to IDLE.
- flush=1 in ISSUE or EXEC: go to FLUSH. No response is produced and rsp_timeout stays 0. flush in IDLE or RESP is ignored.
- Watchdog is cleared on every entry to ISSUE. It saturates and does not wrap.
- alu_* operand outputs hold their last values outside ISSUE/EXEC; there is no glitching to zero.

## Timing
- Reset values: state=IDLE; req_ready=1; rsp_valid=0; every rsp_* output is 0; alu_a, alu_b, alu_op and alu_shamt are 0; alu_ex_stall=1; alu_ex_flush=0; watchdog=0.
- A reset asserted mid-operation returns the block to IDLE on the next edge and discards any pending response.
- Single-cycle op (alu_stall low in first EXEC cycle): request accepted at cycle 0 edge, rsp_valid high at cycle 3. Minimum latency is 3 cycles.
- Multi-cycle op: latency is 3 plus the number of EXEC cycles with alu_stall=1.
- Throughput is one operation outstanding at a time. req_ready=0 in every state except IDLE.
- rsp_valid stays high until handshaked and is never dropped. rsp_ready sampled while rsp_valid=0 has no effect.
- flush and a completing alu_stall=0 in the same EXEC cycle: flush wins and no response is produced.

## Structure
- Package alu_seq_pkg holds the state enum (alu_seq_state_t) and a response struct (alu_rsp_t: result, hi, lo, bzero, ov, timeout). The ALU opcode constants already shared with the ALU move into this package.
- One sub-module: alu_seq_watchdog, a saturating counter with clear, enable and a hit output.

## Test plan
- ADD: A=32'd7, B=32'd5, ALU stall held low. Required: rsp_valid at cycle 3, rsp_result=32'd12, rsp_bzero=0, rsp_ov=0.
- Signed overflow: A=32'h7FFFFFFF, B=32'd1, ADD. Required: rsp_ov=1, rsp_timeout=0.
- MULT: A=32'hFFFFFFFF, B=32'd2, alu_stall high for 32 cycles. Required: rsp_valid at cycle 35, rsp_hi=32'hFFFFFFFF, rsp_lo=32'hFFFFFFFE.
- Watchdog: alu_stall stuck high. Required: alu_ex_flush pulses exactly once at EXEC cycle 200, followed by rsp_valid=1, rsp_timeout=1, rsp_result=0.
- flush asserted in the 5th EXEC cycle of a DIV. Required: one alu_ex_flush pulse, no rsp_valid, req_ready=1 two cycles later.
- Backpressure: rsp_ready held low for 10 cycles with a second req_valid pending. Required: req_ready=0 and rsp_* stable throughout; the second request is accepted only after the response handshake.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// ---------------------------------------------------------------------------
// alu_seq_pkg
//   Shared types and constants for the ALU issue sequencer:
//     - alu_seq_state_t : sequencer FSM states
//     - alu_rsp_t       : captured ALU response (result, HI, LO, flags)
//     - ALU_OP_*        : operation codes understood by the 32-bit MIPS ALU
//     - is_muldiv()     : true for operations that use the multi-cycle unit
//     - timeout_rsp()   : response word produced by a watchdog abort
// ---------------------------------------------------------------------------
package alu_seq_pkg;

    localparam int DATA_W  = 32;
    localparam int OP_W    = 5;
    localparam int SHAMT_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_EXEC  = 3'd2,
        ST_RESP  = 3'd3,
        ST_FLUSH = 3'd4
    } alu_seq_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
        logic              bzero;
        logic              ov;
        logic              timeout;
    } alu_rsp_t;

    // ALU operation codes.
    localparam logic [OP_W-1:0] ALU_OP_ADD   = 5'd0;
    localparam logic [OP_W-1:0] ALU_OP_ADDU  = 5'd1;
    localparam logic [OP_W-1:0] ALU_OP_SUB   = 5'd2;
    localparam logic [OP_W-1:0] ALU_OP_SUBU  = 5'd3;
    localparam logic [OP_W-1:0] ALU_OP_AND   = 5'd4;
    localparam logic [OP_W-1:0] ALU_OP_OR    = 5'd5;
    localparam logic [OP_W-1:0] ALU_OP_XOR   = 5'd6;
    localparam logic [OP_W-1:0] ALU_OP_NOR   = 5'd7;
    localparam logic [OP_W-1:0] ALU_OP_SLT   = 5'd8;
    localparam logic [OP_W-1:0] ALU_OP_SLTU  = 5'd9;
    localparam logic [OP_W-1:0] ALU_OP_SLL   = 5'd10;
    localparam logic [OP_W-1:0] ALU_OP_SRL   = 5'd11;
    localparam logic [OP_W-1:0] ALU_OP_SRA   = 5'd12;
    localparam logic [OP_W-1:0] ALU_OP_MULT  = 5'd16;
    localparam logic [OP_W-1:0] ALU_OP_MULTU = 5'd17;
    localparam logic [OP_W-1:0] ALU_OP_DIV   = 5'd18;
    localparam logic [OP_W-1:0] ALU_OP_DIVU  = 5'd19;

    // Operations that run in the multi-cycle HI/LO unit and raise ALU_Stall.
    function automatic logic is_muldiv(input logic [OP_W-1:0] op);
        return (op == ALU_OP_MULT) || (op == ALU_OP_MULTU) ||
               (op == ALU_OP_DIV)  || (op == ALU_OP_DIVU);
    endfunction

    // A watchdog abort returns zeroed data with only the timeout flag set.
    function automatic alu_rsp_t timeout_rsp();
        alu_rsp_t r;
        r         = '0;
        r.timeout = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/alu_seq_watchdog.sv
// ---------------------------------------------------------------------------
// alu_seq_watchdog
//   Saturating stall counter. Counts enabled cycles since the last clear and
//   flags the enabled cycle that brings the count to LIMIT (LIMIT >= 1).
//
//   clock   in  design clock, rising edge
//   reset   in  synchronous, active-high
//   clear   in  restart the count from zero (wins over enable)
//   enable  in  count this cycle
//   hit     out this enabled cycle is the LIMIT-th one (or later)
// ---------------------------------------------------------------------------
module alu_seq_watchdog #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] LIMIT = 8'd200
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic hit
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            // Stops at LIMIT so a stuck stall can never wrap back to zero.
            count <= count + 1'b1;
        end
    end

    // Combinational so the owner can act in the same cycle the limit is hit.
    assign hit = enable && (count >= (LIMIT - 1'b1));

endmodule

// File: rtl/alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// alu_seq_ctrl
//   Issue sequencer between an instruction-side requester and the 32-bit
//   MIPS ALU. Accepts one operation at a time, presents it to the ALU for a
//   single cycle, waits out ALU_Stall, captures the ALU outputs into a
//   response register and returns it over a valid/ready handshake. A stall
//   watchdog aborts stuck operations; an external flush aborts silently.
//
//   clock, reset                         clock / synchronous active-high reset
//   req_valid/req_ready, req_a, req_b,
//   req_op, req_shamt                    request channel
//   flush                                abort the in-flight operation
//   rsp_valid/rsp_ready, rsp_result,
//   rsp_hi, rsp_lo, rsp_bzero, rsp_ov,
//   rsp_timeout                          response channel
//   alu_a, alu_b, alu_op, alu_shamt,
//   alu_ex_stall, alu_ex_flush           drive to the ALU
//   alu_result, alu_hi, alu_lo,
//   alu_bzero, alu_ov, alu_stall         return from the ALU
// ---------------------------------------------------------------------------
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int                   TIMEOUT_W   = 8,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_MAX = 8'd200
) (
    input  logic                clock,
    input  logic                reset,

    input  logic                req_valid,
    output logic                req_ready,
    input  logic [DATA_W-1:0]   req_a,
    input  logic [DATA_W-1:0]   req_b,
    input  logic [OP_W-1:0]     req_op,
    input  logic [SHAMT_W-1:0]  req_shamt,

    input  logic                flush,

    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_result,
    output logic [DATA_W-1:0]   rsp_hi,
    output logic [DATA_W-1:0]   rsp_lo,
    output logic                rsp_bzero,
    output logic                rsp_ov,
    output logic                rsp_timeout,

    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    output logic [OP_W-1:0]     alu_op,
    output logic [SHAMT_W-1:0]  alu_shamt,
    output logic                alu_ex_stall,
    output logic                alu_ex_flush,

    input  logic [DATA_W-1:0]   alu_result,
    input  logic [DATA_W-1:0]   alu_hi,
    input  logic [DATA_W-1:0]   alu_lo,
    input  logic                alu_bzero,
    input  logic                alu_ov,
    input  logic                alu_stall
);

    alu_seq_state_t state;
    alu_seq_state_t state_next;
    alu_rsp_t       rsp_q;

    logic accept;        // request taken this cycle
    logic exec_done;     // ALU finished and nothing aborts it
    logic exec_timeout;  // watchdog expires this cycle
    logic abort;         // external flush of the in-flight operation
    logic wd_enable;
    logic wd_hit;

    // -----------------------------------------------------------------------
    // Cycle qualifiers. flush is checked first everywhere so that it beats a
    // completing ALU in the same EXEC cycle.
    // -----------------------------------------------------------------------
    assign accept       = (state == ST_IDLE) && req_valid;
    assign abort        = ((state == ST_ISSUE) || (state == ST_EXEC)) && flush;
    assign exec_done    = (state == ST_EXEC) && !flush && !alu_stall;
    assign wd_enable    = (state == ST_EXEC) && !flush && alu_stall;
    assign exec_timeout = wd_hit;

    // Cleared on entry to ISSUE, so every operation gets a full budget.
    alu_seq_watchdog #(
        .WIDTH (TIMEOUT_W),
        .LIMIT (TIMEOUT_MAX)
    ) u_watchdog (
        .clock  (clock),
        .reset  (reset),
        .clear  (accept),
        .enable (wd_enable),
        .hit    (wd_hit)
    );

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking (<=) so every flop samples the
    // pre-edge values of the others, independent of block ordering.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    // NOTE: state_next is given a default before the case so every path
    // assigns it; a missing assignment here would infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (req_valid) state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                state_next = flush ? ST_FLUSH : ST_EXEC;
            end
            ST_EXEC: begin
                if (flush)             state_next = ST_FLUSH;
                else if (!alu_stall)   state_next = ST_RESP;
                else if (exec_timeout) state_next = ST_FLUSH;
            end
            ST_RESP: begin
                if (rsp_ready) state_next = ST_IDLE;
            end
            ST_FLUSH: begin
                // A watchdog abort still owes the requester a response; an
                // external flush does not.
                state_next = rsp_q.timeout ? ST_RESP : ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        alu_ex_stall = 1'b1;
        alu_ex_flush = 1'b0;
        case (state)
            ST_IDLE:  req_ready    = 1'b1;
            // The only cycle the ALU EX stage is allowed to advance.
            ST_ISSUE: alu_ex_stall = 1'b0;
            ST_RESP:  rsp_valid    = 1'b1;
            ST_FLUSH: alu_ex_flush = 1'b1;
            default:  ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Operand register. Loaded only on accept, so the ALU pins hold the last
    // operation while idle instead of dropping to zero.
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            alu_shamt <= '0;
        end else if (accept) begin
            alu_a     <= req_a;
            alu_b     <= req_b;
            alu_op    <= req_op;
            alu_shamt <= req_shamt;
        end
    end

    // -----------------------------------------------------------------------
    // Response register. Written only on leaving EXEC/ISSUE, so it is stable
    // for the whole RESP window. An external abort zeroes it so a stale
    // timeout flag cannot steer FLUSH into RESP.
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            rsp_q <= '0;
        end else if (abort) begin
            rsp_q <= '0;
        end else if (exec_done) begin
            rsp_q <= '{result:  alu_result,
                       hi:      alu_hi,
                       lo:      alu_lo,
                       bzero:   alu_bzero,
                       ov:      alu_ov,
                       timeout: 1'b0};
        end else if (exec_timeout) begin
            rsp_q <= timeout_rsp();
        end
    end

    assign rsp_result  = rsp_q.result;
    assign rsp_hi      = rsp_q.hi;
    assign rsp_lo      = rsp_q.lo;
    assign rsp_bzero   = rsp_q.bzero;
    assign rsp_ov      = rsp_q.ov;
    assign rsp_timeout = rsp_q.timeout;

endmodule
